// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared types and constants for the sequential multiplier.
//   state_t        - controller state encoding (IDLE, RUN)
//   SEQ_MUL_WIDTH  - default operand width in bits
package seq_mul_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SEQ_MUL_WIDTH = 4;

endpackage : seq_mul_pkg

// File: rtl/seq_mul.sv
// seq_mul: unsigned shift-and-add multiplier, one multiplier bit per clock.
// Ports:
//   clk     in   1        rising-edge clock
//   rst     in   1        synchronous active-low reset
//   start   in   1        request, accepted only while idle
//   a       in   WIDTH    multiplicand, captured on accept
//   b       in   WIDTH    multiplier, captured on accept
//   product out  2*WIDTH  registered a*b, held until the next completion
//   done    out  1        registered one-cycle completion pulse
// Latency: product/done update exactly WIDTH edges after the accepting edge.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                 r_state;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_product;
    logic                   r_done;

    state_t                 w_state_nxt;
    logic [2*WIDTH-1:0]     w_add;
    logic [2*WIDTH-1:0]     w_acc_sum;
    logic [2*WIDTH-1:0]     w_acc_nxt;
    logic [2*WIDTH-1:0]     w_mcand_nxt;
    logic [WIDTH-1:0]       w_mplier_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [2*WIDTH-1:0]     w_product_nxt;
    logic                   w_done_nxt;

    // Partial product for this iteration: the shifted multiplicand, gated by the multiplier LSB.
    assign w_add     = r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}};
    assign w_acc_sum = r_acc + w_add;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_mcand_nxt   = r_mcand;
        w_mplier_nxt  = r_mplier;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_mcand_nxt  = {{WIDTH{1'b0}}, a};
                    w_mplier_nxt = b;
                    w_acc_nxt    = {(2*WIDTH){1'b0}};
                    w_cnt_nxt    = {CNT_W{1'b0}};
                    w_state_nxt  = RUN;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            RUN: begin
                w_acc_nxt    = w_acc_sum;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + CNT_ONE;
                // Last iteration publishes the sum including this edge's add.
                if (r_cnt == CNT_LAST) begin
                    w_product_nxt = w_acc_sum;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_state_nxt   = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc     <= {(2*WIDTH){1'b0}};
            r_mcand   <= {(2*WIDTH){1'b0}};
            r_mplier  <= {WIDTH{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_product <= {(2*WIDTH){1'b0}};
            r_done    <= 1'b0;
        end else begin
            r_acc     <= w_acc_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign product = r_product;
    assign done    = r_done;

endmodule : seq_mul

// File: tb/tb_seq_mul.sv
// tb_seq_mul: self-checking bench for seq_mul (WIDTH=4) with an expected-product queue.
module tb_seq_mul;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   product;
    logic             done;

    int               checks = 0;
    int               errors = 0;
    logic [2*W-1:0]   exp_q[$];

    seq_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (done)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present operands with start high and record the expected product.
    task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [2*W-1:0] e;
        a = av;
        b = bv;
        start = 1'b1;
        e = 8'(av) * 8'(bv);
        exp_q.push_back(e);
    endtask

    // Tick until done is seen or limit edges pass; reports edges consumed.
    task automatic wait_done(input int limit, output int edges, output bit seen);
        edges = 0;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            edges++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b1;
        checks++;
        if (product !== 8'd0) begin errors++; $display("FAIL reset_product got %0d want 0", product); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL idle_no_done cyc %0d got %b want 0", i, done); end
        end
    endtask

    // Single operation: latency, product, and hold afterwards.
    task automatic test_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string nm);
        int n; bit seen; logic [2*W-1:0] e;
        drive_start(av, bv);
        tick();
        start = 1'b0;
        a = ~av; b = ~bv;
        wait_done(12, n, seen);
        checks++;
        if (!seen || n != W) begin errors++; $display("FAIL %s_latency got seen=%0d edges=%0d want edges=%0d", nm, seen, n, W); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (product !== e) begin errors++; $display("FAIL %s_product got %0d want %0d", nm, product, e); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || product !== e) begin
                errors++; $display("FAIL %s_hold cyc %0d got done=%b product=%0d want done=0 product=%0d", nm, i, done, product, e);
            end
        end
    endtask

    // start pulsed during RUN (including the final RUN edge) must be ignored.
    task automatic test_ignore_start();
        logic [2*W-1:0] e;
        drive_start(4'd5, 4'd3);
        tick();                          // E0 accept
        start = 1'b0;
        tick();                          // E1
        a = 4'd7; b = 4'd7; start = 1'b1;
        tick();                          // E2
        tick();                          // E3
        tick();                          // E4 final edge, start still high
        start = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL ignore_done_at_e4 got %b want 1", done); end
        checks++;
        if (product !== e) begin errors++; $display("FAIL ignore_product got %0d want %0d", product, e); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || product !== e) begin
                errors++; $display("FAIL ignore_single_done cyc %0d got done=%b product=%0d want done=0 product=%0d", i, done, product, e);
            end
        end
    endtask

    // Reset mid-run aborts without a done pulse; a later op works normally.
    task automatic test_abort();
        a = 4'd9; b = 4'd9; start = 1'b1;
        tick();                          // E0 accept
        start = 1'b0;
        tick();                          // E1
        rst = 1'b0;
        tick();                          // E2 with reset
        rst = 1'b1;
        checks++;
        if (product !== 8'd0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_clear got done=%b product=%0d want done=0 product=0", done, product);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done cyc %0d got %b want 0", i, done); end
        end
        test_op(4'd2, 4'd6, "after_abort");
    endtask

    // start held high: next op accepted on the first idle edge, done pulses 5 edges apart.
    task automatic test_back_to_back();
        int n; bit seen; logic [2*W-1:0] e;
        drive_start(4'd4, 4'd4);
        tick();                          // accept
        wait_done(12, n, seen);
        checks++;
        if (!seen || n != W) begin errors++; $display("FAIL b2b_first_latency got seen=%0d edges=%0d want %0d", seen, n, W); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (product !== e) begin errors++; $display("FAIL b2b_first_product got %0d want %0d", product, e); end
        drive_start(4'd6, 4'd5);         // start stays high
        wait_done(12, n, seen);
        start = 1'b0;
        checks++;
        if (!seen || n != W + 1) begin errors++; $display("FAIL b2b_spacing got seen=%0d edges=%0d want %0d", seen, n, W + 1); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (product !== e) begin errors++; $display("FAIL b2b_second_product got %0d want %0d", product, e); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL b2b_quiet cyc %0d got %b want 0", i, done); end
        end
    endtask

    initial begin
        test_reset();
        test_op(4'd3, 4'd2, "basic_3x2");
        test_op(4'd15, 4'd15, "max_15x15");
        test_op(4'd0, 4'd9, "zero_0x9");
        test_op(4'd11, 4'd0, "zero_11x0");
        test_ignore_start();
        test_abort();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty got %0d left want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mul
